// File: rtl/nes_button_events_if.sv
// Bundles the NES reader inputs and the debounced event outputs of nes_button_events.
interface nes_button_events_if;
    logic       latchOrange;
    logic [7:0] buttons;
    logic       frame_tick;
    logic [7:0] held;
    logic [7:0] pressed;
    logic [7:0] released;
    logic [7:0] repeat_evt;
    logic       lost;

    modport master (
        output latchOrange, buttons,
        input  frame_tick, held, pressed, released, repeat_evt, lost
    );

    modport slave (
        input  latchOrange, buttons,
        output frame_tick, held, pressed, released, repeat_evt, lost
    );
endinterface

// File: rtl/nes_button_events.sv
// Synchronises NES controller frames into the system clock, debounces each button per frame,
// and produces held levels, press/release/auto-repeat pulses and a lost-controller flag.
module nes_button_events #(
    parameter int         DEBOUNCE_FRAMES = 2,
    parameter int         REPEAT_DELAY    = 8,
    parameter int         REPEAT_RATE     = 3,
    parameter logic [7:0] REPEAT_MASK     = 8'h0F,
    parameter int         TIMEOUT_CYCLES  = 4096
) (
    input  logic          clock,
    input  logic          reset,
    nes_button_events_if.slave bus
);
    localparam int             TW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0]     DF     = 4'(DEBOUNCE_FRAMES);
    localparam logic [7:0]     RDELAY = 8'(REPEAT_DELAY);
    localparam logic [7:0]     RLOAD  = 8'(REPEAT_DELAY - REPEAT_RATE);
    localparam logic [TW-1:0]  TMAX   = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]  TLAST  = TW'(TIMEOUT_CYCLES - 1);

    logic            r_latch_s1, r_latch_s2, r_latch_s3;
    logic [7:0]      r_btn_s1, r_btn_s2;
    logic            r_frame_tick;
    logic [7:0]      r_cand, r_held, r_pressed, r_released, r_repeat;
    logic [7:0][3:0] r_cnt;
    logic [7:0][7:0] r_rcnt;
    logic [TW-1:0]   r_tcnt;
    logic            r_lost;

    logic [7:0]      w_cand, w_held, w_pressed, w_released, w_repeat;
    logic [7:0][3:0] w_cnt;
    logic [7:0][7:0] w_rcnt, w_rinc;
    logic            w_timeout;

    // A frame in the same cycle as saturation takes priority, so no lost is raised.
    assign w_timeout = ~r_frame_tick & (r_tcnt == TLAST);

    always_comb begin
        w_cand     = r_cand;
        w_cnt      = r_cnt;
        w_held     = r_held;
        w_rcnt     = r_rcnt;
        w_rinc     = '0;
        w_pressed  = '0;
        w_released = '0;
        w_repeat   = '0;
        if (r_frame_tick) begin
            for (int i = 0; i < 8; i++) begin
                if (r_btn_s2[i] != r_cand[i]) begin
                    w_cand[i] = r_btn_s2[i];
                    w_cnt[i]  = 4'd1;
                end else if (r_cnt[i] < DF) begin
                    w_cnt[i]  = r_cnt[i] + 4'd1;
                end
                if ((w_cnt[i] == DF) && (w_cand[i] != r_held[i]))
                    w_held[i] = w_cand[i];
                w_pressed[i]  = w_held[i] & ~r_held[i];
                w_released[i] = ~w_held[i] & r_held[i];
                w_rinc[i]     = r_rcnt[i] + 8'd1;
                // A fresh press restarts the repeat count; it pulses only on later frames.
                if (!REPEAT_MASK[i] || w_pressed[i] || !w_held[i]) begin
                    w_rcnt[i] = '0;
                end else if (w_rinc[i] == RDELAY) begin
                    w_repeat[i] = 1'b1;
                    w_rcnt[i]   = RLOAD;
                end else begin
                    w_rcnt[i] = w_rinc[i];
                end
            end
        end else if (w_timeout) begin
            w_cand     = '0;
            w_cnt      = '0;
            w_held     = '0;
            w_rcnt     = '0;
            w_released = r_held;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_latch_s1   <= 1'b0;
            r_latch_s2   <= 1'b0;
            r_latch_s3   <= 1'b0;
            r_btn_s1     <= '0;
            r_btn_s2     <= '0;
            r_frame_tick <= 1'b0;
            r_cand       <= '0;
            r_cnt        <= '0;
            r_held       <= '0;
            r_rcnt       <= '0;
            r_pressed    <= '0;
            r_released   <= '0;
            r_repeat     <= '0;
            r_tcnt       <= '0;
            r_lost       <= 1'b0;
        end else begin
            r_latch_s1   <= bus.latchOrange;
            r_latch_s2   <= r_latch_s1;
            r_latch_s3   <= r_latch_s2;
            r_btn_s1     <= bus.buttons;
            r_btn_s2     <= r_btn_s1;
            r_frame_tick <= r_latch_s2 & ~r_latch_s3;
            r_cand       <= w_cand;
            r_cnt        <= w_cnt;
            r_held       <= w_held;
            r_rcnt       <= w_rcnt;
            r_pressed    <= w_pressed;
            r_released   <= w_released;
            r_repeat     <= w_repeat;
            if (r_frame_tick) begin
                r_tcnt <= '0;
                r_lost <= 1'b0;
            end else begin
                if (r_tcnt != TMAX)
                    r_tcnt <= r_tcnt + 1'b1;
                if (w_timeout)
                    r_lost <= 1'b1;
            end
        end
    end

    assign bus.frame_tick = r_frame_tick;
    assign bus.held       = r_held;
    assign bus.pressed    = r_pressed;
    assign bus.released   = r_released;
    assign bus.repeat_evt = r_repeat;
    assign bus.lost       = r_lost;
endmodule
